// File: rtl/fn_unit.sv
// fn_unit: one-deep registered AND/XOR/OR/ADD unit with valid/ready handshakes.
// Optional accumulator operand path is compiled in with `define FN_UNIT_ACC_EN.
module fn_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
`ifdef FN_UNIT_ACC_EN
    input  logic             acc_mode,
    input  logic             acc_clr,
`endif
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic [CNT_W-1:0] op_cnt
);

    typedef enum logic [1:0] {
        FN_AND = 2'b00,
        FN_XOR = 2'b01,
        FN_OR  = 2'b10,
        FN_ADD = 2'b11
    } fn_e;

    logic             in_xfer;
    logic             out_xfer;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res_y;
    logic             res_c;

    assign in_ready = !out_valid || out_ready;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

`ifdef FN_UNIT_ACC_EN
    logic [WIDTH-1:0] acc;

    // A same-cycle clear makes the accumulator operand read as zero.
    always_comb begin
        op_a = a;
        if (acc_mode) begin
            op_a = acc_clr ? '0 : acc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (in_xfer && acc_mode) begin
            acc <= res_y;
        end else if (acc_clr) begin
            acc <= '0;
        end
    end
`else
    assign op_a = a;
`endif

    assign sum = {1'b0, op_a} + {1'b0, b};

    always_comb begin
        res_y = '0;
        res_c = 1'b0;
        unique case (fn_e'(sel))
            FN_AND: res_y = op_a & b;
            FN_XOR: res_y = op_a ^ b;
            FN_OR:  res_y = op_a | b;
            FN_ADD: begin
                res_y = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
            end
            default: res_y = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            carry     <= 1'b0;
            op_cnt    <= '0;
        end else if (in_xfer) begin
            out_valid <= 1'b1;
            y         <= res_y;
            carry     <= res_c;
            op_cnt    <= op_cnt + CNT_W'(1);
        end else if (out_xfer) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fn_unit.sv
// Self-checking bench for fn_unit (WIDTH=8, CNT_W=4): directed cases plus random
// traffic against a transaction-level reference. Define FN_UNIT_ACC_EN to cover the accumulator.
module tb_fn_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] sel;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
    logic       carry;
    logic [3:0] op_cnt;
`ifdef FN_UNIT_ACC_EN
    logic       acc_mode;
    logic       acc_clr;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: held result, its validity, count of accepted sets, accumulator.
    logic       m_valid = 1'b0;
    logic [7:0] m_y     = '0;
    logic       m_c     = 1'b0;
    int         m_cnt   = 0;
    logic [7:0] m_acc   = '0;

    logic [7:0] sweep_y [4];

    fn_unit #(.WIDTH(8), .CNT_W(4)) dut (
`ifdef FN_UNIT_ACC_EN
        .acc_mode (acc_mode),
        .acc_clr  (acc_clr),
`endif
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .sel      (sel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y        (y),
        .carry    (carry),
        .op_cnt   (op_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // {carry, y} for one operation, from plain integer arithmetic.
    function automatic logic [8:0] ref_op(input logic [1:0] s, input logic [7:0] x, input logic [7:0] z);
        int sum;
        case (s)
            2'd0:    return {1'b0, x & z};
            2'd1:    return {1'b0, x ^ z};
            2'd2:    return {1'b0, x | z};
            default: begin
                sum = int'(x) + int'(z);
                return {1'(sum / 256), 8'(sum % 256)};
            end
        endcase
    endfunction

    // One clock: check in_ready before the edge, update the reference, check outputs after it.
    task automatic cycle();
        logic       rdy;
        logic [7:0] opa;
        logic [8:0] r;
        logic       acc_use;
        logic       acc_zero;
        #1;
        rdy = !m_valid || out_ready;
        check("in_ready", in_ready, rdy);
        acc_use  = 1'b0;
        acc_zero = 1'b0;
`ifdef FN_UNIT_ACC_EN
        acc_use  = acc_mode;
        acc_zero = acc_clr;
`endif
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_y = '0; m_c = 1'b0; m_cnt = 0; m_acc = '0;
        end else begin
            if (in_valid && rdy) begin
                opa = acc_use ? (acc_zero ? 8'h00 : m_acc) : a;
                r = ref_op(sel, opa, b);
                m_y = r[7:0];
                m_c = r[8];
                m_valid = 1'b1;
                m_cnt = (m_cnt + 1) % 16;
                if (acc_use) m_acc = m_y;
                else if (acc_zero) m_acc = '0;
            end else begin
                if (m_valid && out_ready) m_valid = 1'b0;
                if (acc_zero) m_acc = '0;
            end
        end
        #1;
        check("out_valid", out_valid, m_valid);
        check("y", y, m_y);
        check("carry", carry, m_c);
        check("op_cnt", op_cnt, m_cnt);
    endtask

    task automatic drive(input logic v, input logic [7:0] xa, input logic [7:0] xb, input logic [1:0] s);
        in_valid = v; a = xa; b = xb; sel = s;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        sweep_y[0] = 8'h42; sweep_y[1] = 8'h99; sweep_y[2] = 8'hDB; sweep_y[3] = 8'h1D;
        rst = 1'b1; out_ready = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 2'd0);
`ifdef FN_UNIT_ACC_EN
        acc_mode = 1'b0; acc_clr = 1'b0;
`endif
        do_reset();
        check("rst_y", y, 32'h0);
        check("rst_valid", out_valid, 32'h0);
        check("ready_after_rst", in_ready, 32'h1);

        // Function sweep with fixed operands
        for (int unsigned s = 0; s < 4; s++) begin
            drive(1'b1, 8'hC3, 8'h5A, 2'(s));
            cycle();
            check("sweep_y", y, sweep_y[s]);
            check("sweep_carry", carry, (s == 3) ? 32'h1 : 32'h0);
        end

        // Add boundaries
        drive(1'b1, 8'hFF, 8'h01, 2'd3); cycle();
        check("add_wrap_y", y, 32'h00);
        check("add_wrap_c", carry, 32'h1);
        drive(1'b1, 8'h7F, 8'h01, 2'd3); cycle();
        check("add_80_y", y, 32'h80);
        check("add_80_c", carry, 32'h0);

        // Backpressure: held result must not move while in_valid keeps offering new sets
        out_ready = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            drive(1'b1, 8'(i * 17 + 3), 8'h11, 2'(i));
            cycle();
            check("stall_ready", in_ready, 32'h0);
            check("stall_y", y, 32'h80);
        end
        out_ready = 1'b1;
        drive(1'b1, 8'h0F, 8'hF0, 2'd2);
        cycle();
        check("release_y", y, 32'hFF);
        check("release_valid", out_valid, 32'h1);

        // Back-to-back stream of 8 from a clean counter
        do_reset();
        for (int unsigned i = 0; i < 8; i++) begin
            drive(1'b1, 8'($urandom), 8'($urandom), 2'($urandom));
            cycle();
        end
        check("stream_cnt", op_cnt, 32'd8);
        drive(1'b0, 8'h00, 8'h00, 2'd0);
        cycle();
        check("drain_valid", out_valid, 32'h0);

        // Counter wrap, then reset with a result pending
        do_reset();
        for (int unsigned i = 0; i < 17; i++) begin
            drive(1'b1, 8'($urandom), 8'($urandom), 2'd3);
            cycle();
        end
        check("wrap_cnt", op_cnt, 32'd1);
        out_ready = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        out_ready = 1'b1;
        check("rst_mid_valid", out_valid, 32'h0);
        check("rst_mid_y", y, 32'h0);
        check("rst_mid_cnt", op_cnt, 32'h0);

`ifdef FN_UNIT_ACC_EN
        // Accumulate b=5 three times from a cleared accumulator
        drive(1'b0, 8'h00, 8'h00, 2'd0);
        acc_clr = 1'b1; cycle(); acc_clr = 1'b0;
        acc_mode = 1'b1;
        for (int unsigned i = 1; i <= 3; i++) begin
            drive(1'b1, 8'hAA, 8'h05, 2'd3);
            cycle();
            check("acc_y", y, 32'(5 * i));
        end
        acc_mode = 1'b0;
`endif

        // Random traffic
        for (int unsigned i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            drive(1'($urandom), 8'($urandom), 8'($urandom), 2'($urandom));
`ifdef FN_UNIT_ACC_EN
            acc_mode = 1'($urandom);
            acc_clr  = ($urandom_range(0, 7) == 0);
`endif
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
